// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan gate sweeper: FSM states, vector count
// and counter widths used by the sweeper, its interface and the testbench.
package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } sweepState_t;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = $clog2(NUM_VECTORS);
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned ERR_W       = 3;

endpackage

// File: rtl/demorgan_sweeper_if.sv
// Control and gate-under-test signal bundle for demorgan_sweeper.
// slave is the sweeper's view, master is the controller/gate side.
interface demorgan_sweeper_if;

  logic                             start;
  logic                             abort;
  logic                             dut_a;
  logic                             dut_b;
  logic                             dut_and;
  logic                             dut_nand;
  logic                             busy;
  logic                             done;
  logic                             pass;
  logic [demorgan_pkg::ERR_W-1:0]   err_count;
  logic [demorgan_pkg::NUM_VECTORS-1:0] fail_vec;

  modport master (
    output start, abort, dut_and, dut_nand,
    input  dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, abort, dut_and, dut_nand,
    output dut_a, dut_b, busy, done, pass, err_count, fail_vec
  );

endinterface

// File: rtl/demorgan_golden.sv
// Expected AND/NAND outputs for one input vector of the gate under test.
module demorgan_golden (
  input  logic a,
  input  logic b,
  output logic exp_and,
  output logic exp_nand
);

  assign exp_and  = a & b;
  // NAND expressed in its De Morgan form so it is not just ~exp_and.
  assign exp_nand = ~a | ~b;

endmodule

// File: rtl/demorgan_sweeper.sv
// Walks a two-input gate through all four input vectors, checks its AND and
// NAND outputs against the golden values and reports per-vector mismatches.
module demorgan_sweeper
  import demorgan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  demorgan_sweeper_if.slave bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
    $error("demorgan_sweeper: SETTLE_CYCLES must be 1..15");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  sweepState_t      state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] nextVec;
  logic [CNT_W-1:0] settleCnt;
  logic             expAnd;
  logic             expNand;
  logic             mismatch;

  demorgan_golden golden (
    .a       (vec[1]),
    .b       (vec[0]),
    .exp_and (expAnd),
    .exp_nand(expNand)
  );

  assign mismatch = (bus.dut_and != expAnd) || (bus.dut_nand != expNand);
  assign nextVec  = vec + VEC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      vec           <= '0;
      settleCnt     <= '0;
      bus.dut_a     <= 1'b0;
      bus.dut_b     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_count <= '0;
      bus.fail_vec  <= '0;
    end else begin
      bus.done <= 1'b0;
      // Abort takes priority in every active state; partial results are kept.
      if (state != IDLE && bus.abort) begin
        state     <= IDLE;
        bus.busy  <= 1'b0;
        bus.dut_a <= 1'b0;
        bus.dut_b <= 1'b0;
        bus.pass  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state         <= SETTLE;
              vec           <= '0;
              settleCnt     <= '0;
              bus.dut_a     <= 1'b0;
              bus.dut_b     <= 1'b0;
              bus.busy      <= 1'b1;
              bus.pass      <= 1'b0;
              bus.err_count <= '0;
              bus.fail_vec  <= '0;
            end
          end
          SETTLE: begin
            settleCnt <= settleCnt + CNT_W'(1);
            if (settleCnt == SETTLE_LAST) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (mismatch) begin
              bus.fail_vec[vec] <= 1'b1;
              bus.err_count     <= bus.err_count + ERR_W'(1);
            end
            if (vec == LAST_VEC) begin
              state <= DONE;
            end else begin
              state     <= SETTLE;
              vec       <= nextVec;
              settleCnt <= '0;
              bus.dut_a <= nextVec[1];
              bus.dut_b <= nextVec[0];
            end
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_count == '0);
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demorgan_sweeper.sv
// Randomized bench for demorgan_sweeper with a cycle-phase reference model,
// run against two instances (SETTLE_CYCLES = 1 and 3) sharing one stimulus.
module tb_demorgan_sweeper;
  import demorgan_pkg::*;

  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tieNand = 1'b0;
  logic [3:0] andFlip = 4'h0;
  logic [3:0] nandFlip = 4'h0;

  demorgan_sweeper_if bus0 ();
  demorgan_sweeper_if bus1 ();

  demorgan_sweeper #(.SETTLE_CYCLES(S0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  demorgan_sweeper #(.SETTLE_CYCLES(S1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  // Gate model: correct AND/NAND with optional per-vector output flips.
  assign bus0.start    = start;
  assign bus0.abort    = abort;
  assign bus0.dut_and  = (bus0.dut_a & bus0.dut_b) ^ andFlip[{bus0.dut_a, bus0.dut_b}];
  assign bus0.dut_nand = tieNand ? 1'b0 : (~(bus0.dut_a & bus0.dut_b) ^ nandFlip[{bus0.dut_a, bus0.dut_b}]);
  assign bus1.start    = start;
  assign bus1.abort    = abort;
  assign bus1.dut_and  = (bus1.dut_a & bus1.dut_b) ^ andFlip[{bus1.dut_a, bus1.dut_b}];
  assign bus1.dut_nand = tieNand ? 1'b0 : (~(bus1.dut_a & bus1.dut_b) ^ nandFlip[{bus1.dut_a, bus1.dut_b}]);

  logic [1:0] actAB [2];
  logic       actBusy [2];
  logic       actDone [2];
  logic       actPass [2];
  logic [2:0] actErr [2];
  logic [3:0] actFail [2];
  assign actAB[0]   = {bus0.dut_a, bus0.dut_b};
  assign actAB[1]   = {bus1.dut_a, bus1.dut_b};
  assign actBusy[0] = bus0.busy;
  assign actBusy[1] = bus1.busy;
  assign actDone[0] = bus0.done;
  assign actDone[1] = bus1.done;
  assign actPass[0] = bus0.pass;
  assign actPass[1] = bus1.pass;
  assign actErr[0]  = bus0.err_count;
  assign actErr[1]  = bus1.err_count;
  assign actFail[0] = bus0.fail_vec;
  assign actFail[1] = bus1.fail_vec;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase = clock edges since the accepted start (-1 idle).
  // Vector v occupies phases v*(S+1)..v*(S+1)+S, checked at its last phase;
  // phase 4*(S+1) is the completion edge.
  int         mPhase [2] = '{-1, -1};
  logic [1:0] mAB [2]    = '{2'd0, 2'd0};
  logic       mDone [2]  = '{1'b0, 1'b0};
  logic       mPass [2]  = '{1'b0, 1'b0};
  logic [2:0] mErr [2]   = '{3'd0, 3'd0};
  logic [3:0] mFail [2]  = '{4'd0, 4'd0};

  function automatic int settleOf(input int i);
    return (i == 0) ? int'(S0) : int'(S1);
  endfunction

  function automatic logic vecBad(input int v);
    logic nandBad;
    nandBad = tieNand ? (v != 3) : nandFlip[v];
    return andFlip[v] | nandBad;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      int per;
      int last;
      per  = settleOf(i) + 1;
      last = 4 * per;
      if (!reset_n) begin
        mPhase[i] = -1;
        mAB[i]    = 2'd0;
        mDone[i]  = 1'b0;
        mPass[i]  = 1'b0;
        mErr[i]   = 3'd0;
        mFail[i]  = 4'd0;
      end else begin
        mDone[i] = 1'b0;
        if (mPhase[i] < 0) begin
          if (start && !abort) begin
            mPhase[i] = 0;
            mAB[i]    = 2'd0;
            mPass[i]  = 1'b0;
            mErr[i]   = 3'd0;
            mFail[i]  = 4'd0;
          end
        end else if (abort) begin
          mPhase[i] = -1;
          mAB[i]    = 2'd0;
          mPass[i]  = 1'b0;
        end else if (mPhase[i] == last) begin
          mPhase[i] = -1;
          mDone[i]  = 1'b1;
          mPass[i]  = (mErr[i] == 3'd0);
        end else begin
          if (mPhase[i] % per == per - 1 && vecBad(mPhase[i] / per)) begin
            mFail[i][mPhase[i] / per] = 1'b1;
            mErr[i] = mErr[i] + 3'd1;
          end
          mPhase[i] = mPhase[i] + 1;
          mAB[i] = (mPhase[i] / per > 3) ? 2'd3 : 2'(mPhase[i] / per);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("busy%0d", i), actBusy[i], mPhase[i] >= 0);
      check($sformatf("ab%0d", i), actAB[i], mAB[i]);
      check($sformatf("done%0d", i), actDone[i], mDone[i]);
      check($sformatf("pass%0d", i), actPass[i], mPass[i]);
      check($sformatf("err%0d", i), actErr[i], mErr[i]);
      check($sformatf("fail%0d", i), actFail[i], mFail[i]);
    end
  end

  logic [1:0] abHist0 [25];
  logic [1:0] abHist1 [25];
  logic       busyHist0 [25];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Start a sweep, then for edge k = 1..24 optionally apply an extra start,
  // abort or reset sampled at that edge; record first done edge per instance.
  task automatic runSweep(input int extraAt, input int abortAt, input int resetAt,
                          output int d0, output int d1);
    d0 = -1;
    d1 = -1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == extraAt) start = 1'b1;
      if (k == abortAt) abort = 1'b1;
      if (k == resetAt) begin
        reset_n = 1'b0;
        #1;
        check("rstBusy", bus0.busy, 0);
        check("rstDone", bus0.done, 0);
        check("rstAB", {bus0.dut_a, bus0.dut_b}, 0);
        check("rstPass", bus0.pass, 0);
        check("rstErr", bus0.err_count, 0);
        check("rstFail", bus0.fail_vec, 0);
      end
      tick(1);
      start   = 1'b0;
      abort   = 1'b0;
      reset_n = 1'b1;
      abHist0[k]   = {bus0.dut_a, bus0.dut_b};
      abHist1[k]   = {bus1.dut_a, bus1.dut_b};
      busyHist0[k] = bus0.busy;
      if (bus0.done && d0 < 0) d0 = k;
      if (bus1.done && d1 < 0) d1 = k;
    end
    tick(20);
  endtask

  initial begin
    int d0, d1, ea, aa, ra;

    tick(2);
    check("resetBusy", bus0.busy, 0);
    check("resetPass", bus1.pass, 0);
    check("resetFail", bus0.fail_vec, 0);
    reset_n = 1'b1;
    tick(1);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("startAbortIdle", bus0.busy, 0);
    tick(2);

    // correct gate, plain sweep
    runSweep(0, 0, 0, d0, d1);
    check("latency1", d0, 9);
    check("latency3", d1, 17);
    check("pass0", bus0.pass, 1);
    check("err0", bus0.err_count, 0);
    check("failVec0", bus0.fail_vec, 0);
    check("pass1", bus1.pass, 1);
    check("vecOrder1", abHist0[1], 2'b00);
    check("vecOrder2", abHist0[2], 2'b01);
    check("vecOrder4", abHist0[4], 2'b10);
    check("vecOrder6", abHist0[6], 2'b11);
    check("hold3a", abHist1[3], 2'b00);
    check("hold3b", abHist1[4], 2'b01);

    // NAND output stuck low
    tieNand = 1'b1;
    runSweep(0, 0, 0, d0, d1);
    tieNand = 1'b0;
    check("stuckDone", d0, 9);
    check("stuckErr", bus0.err_count, 3);
    check("stuckFail", bus0.fail_vec, 4'b0111);
    check("stuckPass", bus0.pass, 0);

    // abort while {A,B}=10 on the SETTLE_CYCLES=1 instance
    runSweep(0, 5, 0, d0, d1);
    check("abortNoDone", d0, -1);
    check("abortAB", abHist0[5], 2'b00);
    check("abortBusy", busyHist0[5], 0);
    check("abortPass", bus0.pass, 0);
    runSweep(0, 0, 0, d0, d1);
    check("afterAbortPass", bus0.pass, 1);

    // extra start mid-sweep is ignored
    runSweep(3, 0, 0, d0, d1);
    check("extraStartLatency", d0, 9);

    // back-to-back start in the cycle done is high
    runSweep(10, 0, 0, d0, d1);
    check("b2bFirstDone", d0, 9);
    check("b2bAccepted", busyHist0[10], 1);

    // reset mid-sweep, then a sweep with only a vector-3 AND fault
    runSweep(0, 0, 5, d0, d1);
    check("resetNoDone0", d0, -1);
    check("resetNoDone1", d1, -1);
    andFlip = 4'b1000;
    runSweep(0, 0, 0, d0, d1);
    check("vec3Done", d0, 9);
    check("vec3Err", bus0.err_count, 1);
    check("vec3Fail", bus0.fail_vec, 4'b1000);
    check("vec3Pass", bus0.pass, 0);
    andFlip = 4'h0;

    for (int r = 0; r < 40; r++) begin
      andFlip  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      nandFlip = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
      tieNand  = ($urandom_range(0, 7) == 0);
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
      aa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0;
      runSweep(ea, aa, ra, d0, d1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demorgan_sweeper.md
DEMORGAN_SWEEPER -- requirements
Module: demorgan_sweeper

Interface
REQ-001 SETTLE_CYCLES, default 1, meaning: cycles each input vector is held before the gate outputs are checked; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to run a full truth-table sweep; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running sweep.
REQ-006 dut_a  output  1  registered drive to gate input A.
REQ-007 dut_b  output  1  registered drive to gate input B.
REQ-008 dut_and  input  1  observed AND output of the gate under control.
REQ-009 dut_nand  input  1  observed NAND output of the gate under control.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a sweep completes (never on abort).
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 err_count  output  3  number of mismatching vectors in the last sweep (0..4).
REQ-014 fail_vec  output  4  bit i set if vector i ({A,B}=i) mismatched.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE with start=1 and abort=0 SHALL set vec=0, dut_a=0, dut_b=0, settle_cnt=0, clear pass/err_count/fail_vec, and go to SETTLE.
REQ-017 SETTLE SHALL increment settle_cnt each cycle and go to CHECK when settle_cnt reaches SETTLE_CYCLES-1.
REQ-018 CHECK (exactly one cycle) SHALL compare dut_and against A&B and dut_nand against ~(A&B), where A=vec[1], B=vec[0]; any mismatch on either output SHALL set fail_vec[vec] and increment err_count once.
REQ-019 CHECK with vec<3 SHALL increment vec, drive {dut_a,dut_b}=new vec, clear settle_cnt, and return to SETTLE; CHECK with vec=3 SHALL go to DONE.
REQ-020 DONE SHALL assert done for one cycle, set pass=(err_count==0) including any vector-3 mismatch, and return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle 4*(SETTLE_CYCLES+1)+1 cycles after the start edge (9 cycles for SETTLE_CYCLES=1).
REQ-022 Vector order SHALL be {A,B}=00,01,10,11; dut_a/dut_b SHALL be stable throughout each SETTLE+CHECK window.
REQ-023 start outside IDLE SHALL be ignored with no effect on the running sweep.
REQ-024 abort in SETTLE, CHECK or DONE SHALL return to IDLE next edge, drive dut_a=dut_b=0, force pass=0, keep partial err_count/fail_vec, and suppress done.
REQ-025 abort and start together in IDLE: abort wins, start ignored.
REQ-026 pass, err_count, fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-027 Back-to-back: start in the cycle after done (state IDLE) SHALL be accepted.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, vec=0, settle_cnt=0, dut_a=dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-029 Reset asserted mid-sweep SHALL discard the sweep with no done pulse; the first start after reset_n rises SHALL run normally.

Structure
REQ-030 A shared package demorgan_pkg SHALL hold the state encoding, NUM_VECTORS=4 and the settle-counter width (4).
REQ-031 Expected-value generation SHALL live in one combinational sub-module demorgan_golden (inputs A,B; outputs exp_and, exp_nand).

Verification
REQ-032 Correct gate attached, SETTLE_CYCLES=1, start pulse -> dut_a/dut_b step 00,01,10,11; done 9 cycles after start; pass=1, err_count=0, fail_vec=0000.
REQ-033 dut_nand tied to 0, start -> err_count=3, fail_vec=0111, pass=0, done asserted.
REQ-034 SETTLE_CYCLES=3, correct gate, start -> each vector held 4 cycles; done 17 cycles after start; pass=1.
REQ-035 Correct gate, start, then abort while {A,B}=10 -> IDLE next edge, dut_a=dut_b=0, no done, pass=0; new start then passes.
REQ-036 start pulsed again mid-sweep and reset_n pulsed low mid-sweep (separate runs) -> extra start has no effect (done still at cycle 9); reset clears all outputs to 0 and suppresses done.
